// File: rtl/timer_pkg.sv
// Shared constants and types for the timer block: default widths, compare reset
// value and the encoding of the count-update select.
package timer_pkg;

  localparam int CNT_W_DFLT = 64;
  localparam int HALF_W = CNT_W_DFLT / 2;
  localparam logic [CNT_W_DFLT-1:0] CMP_RST_DFLT = {CNT_W_DFLT{1'b1}};

  // Count-update sources, listed highest priority first
  typedef enum logic [1:0] {
    UPD_WR   = 2'd0,
    UPD_CLR  = 2'd1,
    UPD_INC  = 2'd2,
    UPD_HOLD = 2'd3
  } upd_sel_e;

endpackage

// File: rtl/timer_int_ctrl.sv
// Compare match detection, sticky interrupt status with set-over-clear priority,
// and the interrupt output mask.
module timer_int_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             int_en,
  input  logic             int_clr,
  output logic             int_st,
  output logic             tim_int
);

  logic match;
  logic int_st_reg;
  logic int_st_next;

  assign match = (cnt_val == cmp_val);

  always_comb begin
    int_st_next = int_st_reg;
    if (match) begin
      int_st_next = 1'b1;
    end else if (int_clr) begin
      int_st_next = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      int_st_reg <= 1'b0;
    end else begin
      int_st_reg <= int_st_next;
    end
  end

  // Masking only affects the line to the interrupt controller, never the status
  assign int_st  = int_st_reg;
  assign tim_int = int_st_reg & int_en;

endmodule

// File: rtl/timer_core.sv
// Free-running timer counter with split-half register writes, compare/interrupt
// and debug halt handshake.
module timer_core
  import timer_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DFLT,
  parameter logic [CNT_W-1:0] CMP_RST = {CNT_W{1'b1}}
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               timer_en,
  input  logic               cnt_en,
  input  logic               cnt_lo_wr,
  input  logic               cnt_hi_wr,
  input  logic               cmp_lo_wr,
  input  logic               cmp_hi_wr,
  input  logic [CNT_W/2-1:0] wdata,
  input  logic               int_en,
  input  logic               int_clr,
  input  logic               dbg_mode,
  input  logic               halt_req,
  output logic [CNT_W-1:0]   cnt_val,
  output logic [CNT_W-1:0]   cmp_val,
  output logic               int_st,
  output logic               tim_int,
  output logic               halt_ack
);

  localparam int H_W = CNT_W / 2;

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cmp_reg;
  logic [CNT_W-1:0] cmp_next;
  logic             timer_en_reg;
  logic             halt_ack_reg;
  upd_sel_e         upd_sel;

  always_comb begin
    upd_sel = UPD_HOLD;
    if (cnt_lo_wr || cnt_hi_wr) begin
      upd_sel = UPD_WR;
    end else if (timer_en_reg && !timer_en) begin
      upd_sel = UPD_CLR;
    end else if (timer_en && cnt_en && !halt_ack_reg) begin
      upd_sel = UPD_INC;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    unique case (upd_sel)
      UPD_WR: begin
        if (cnt_lo_wr) cnt_next[H_W-1:0] = wdata;
        if (cnt_hi_wr) cnt_next[CNT_W-1:H_W] = wdata;
      end
      UPD_CLR:  cnt_next = '0;
      UPD_INC:  cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      default:  cnt_next = cnt_reg;
    endcase
  end

  // Compare writes ignore enable and halt state
  always_comb begin
    cmp_next = cmp_reg;
    if (cmp_lo_wr) cmp_next[H_W-1:0] = wdata;
    if (cmp_hi_wr) cmp_next[CNT_W-1:H_W] = wdata;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_reg      <= '0;
      cmp_reg      <= CMP_RST;
      timer_en_reg <= 1'b0;
      halt_ack_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      cmp_reg      <= cmp_next;
      timer_en_reg <= timer_en;
      halt_ack_reg <= dbg_mode & halt_req;
    end
  end

  assign cnt_val  = cnt_reg;
  assign cmp_val  = cmp_reg;
  assign halt_ack = halt_ack_reg;

  timer_int_ctrl #(
    .CNT_W (CNT_W)
  ) u_int_ctrl (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cnt_val (cnt_reg),
    .cmp_val (cmp_reg),
    .int_en  (int_en),
    .int_clr (int_clr),
    .int_st  (int_st),
    .tim_int (tim_int)
  );

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core: a behavioural model checked every cycle plus
// literal expectations at the key points of each scenario.
module tb_timer_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        timer_en, cnt_en, cnt_lo_wr, cnt_hi_wr, cmp_lo_wr, cmp_hi_wr;
  logic [31:0] wdata;
  logic        int_en, int_clr, dbg_mode, halt_req;
  logic [63:0] cnt_val, cmp_val;
  logic        int_st, tim_int, halt_ack;

  int checks = 0;
  int failures = 0;

  // Model state
  logic [63:0] m_cnt, m_cmp;
  logic        m_int, m_halt, m_en_prev;

  always #5 sys_clk = ~sys_clk;

  timer_core dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .timer_en  (timer_en),
    .cnt_en    (cnt_en),
    .cnt_lo_wr (cnt_lo_wr),
    .cnt_hi_wr (cnt_hi_wr),
    .cmp_lo_wr (cmp_lo_wr),
    .cmp_hi_wr (cmp_hi_wr),
    .wdata     (wdata),
    .int_en    (int_en),
    .int_clr   (int_clr),
    .dbg_mode  (dbg_mode),
    .halt_req  (halt_req),
    .cnt_val   (cnt_val),
    .cmp_val   (cmp_val),
    .int_st    (int_st),
    .tim_int   (tim_int),
    .halt_ack  (halt_ack)
  );

  // Model: the timer's rules applied once per edge on the sampled inputs
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_cnt <= 64'd0;
      m_cmp <= {64{1'b1}};
      m_int <= 1'b0;
      m_halt <= 1'b0;
      m_en_prev <= 1'b0;
    end else begin
      if (cnt_lo_wr || cnt_hi_wr) begin
        if (cnt_lo_wr) m_cnt[31:0] <= wdata;
        if (cnt_hi_wr) m_cnt[63:32] <= wdata;
      end else if (m_en_prev && !timer_en) begin
        m_cnt <= 64'd0;
      end else if (timer_en && cnt_en && !m_halt) begin
        m_cnt <= m_cnt + 64'd1;
      end
      if (cmp_lo_wr) m_cmp[31:0] <= wdata;
      if (cmp_hi_wr) m_cmp[63:32] <= wdata;
      if (m_cnt == m_cmp) m_int <= 1'b1;
      else if (int_clr) m_int <= 1'b0;
      m_halt <= dbg_mode && halt_req;
      m_en_prev <= timer_en;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    check("model_cnt_val", cnt_val, m_cnt);
    check("model_cmp_val", cmp_val, m_cmp);
    check("model_int_st", {63'd0, int_st}, {63'd0, m_int});
    check("model_tim_int", {63'd0, tim_int}, {63'd0, m_int & int_en});
    check("model_halt_ack", {63'd0, halt_ack}, {63'd0, m_halt});
  endtask

  // One clock; inputs change at the falling edge after outputs are checked
  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
    compare_model();
    $display("cyc t=%0t cnt=%0h cmp=%0h int_st=%b tim_int=%b halt_ack=%b",
             $time, cnt_val, cmp_val, int_st, tim_int, halt_ack);
  endtask

  task automatic clr_strobes();
    cnt_lo_wr = 0; cnt_hi_wr = 0; cmp_lo_wr = 0; cmp_hi_wr = 0;
    cnt_en = 0; int_clr = 0;
  endtask

  task automatic wr_cnt(input logic lo, input logic hi, input logic [31:0] d);
    cnt_lo_wr = lo; cnt_hi_wr = hi; wdata = d;
    tick();
    clr_strobes();
  endtask

  task automatic wr_cmp(input logic lo, input logic hi, input logic [31:0] d);
    cmp_lo_wr = lo; cmp_hi_wr = hi; wdata = d;
    tick();
    clr_strobes();
  endtask

  initial begin
    sys_rst = 1; timer_en = 0; wdata = 0; int_en = 0; dbg_mode = 0; halt_req = 0;
    clr_strobes();
    tick(); tick();
    check("rst_cnt_val", cnt_val, 64'd0);
    check("rst_cmp_val", cmp_val, {64{1'b1}});
    check("rst_int_st", {63'd0, int_st}, 64'd0);
    check("rst_halt_ack", {63'd0, halt_ack}, 64'd0);
    sys_rst = 0;
    tick();

    // Ten ticks, one every second cycle
    timer_en = 1;
    for (int i = 0; i < 10; i++) begin
      cnt_en = 1; tick(); cnt_en = 0; tick();
    end
    check("ten_ticks_cnt", cnt_val, 64'd10);
    check("ten_ticks_int", {63'd0, int_st}, 64'd0);

    // Compare at 5 with interrupts enabled
    wr_cnt(1, 1, 32'd0);
    wr_cmp(0, 1, 32'd0);
    wr_cmp(1, 0, 32'd5);
    int_en = 1;
    for (int i = 0; i < 5; i++) begin
      cnt_en = 1; tick(); cnt_en = 0;
    end
    check("cmp5_cnt", cnt_val, 64'd5);
    check("cmp5_int_before", {63'd0, int_st}, 64'd0);
    tick();
    check("cmp5_int_after", {63'd0, int_st}, 64'd1);
    check("cmp5_tim_int", {63'd0, tim_int}, 64'd1);
    cnt_en = 1; tick(); cnt_en = 0;
    check("cmp5_cnt6", cnt_val, 64'd6);
    int_clr = 1; tick(); int_clr = 0;
    check("clr_at_6", {63'd0, int_st}, 64'd0);

    // Match and clear in the same cycle: set wins
    wr_cnt(1, 0, 32'd5);
    int_clr = 1; tick(); int_clr = 0;
    check("set_beats_clr", {63'd0, int_st}, 64'd1);
    int_en = 0; tick();
    check("masked_tim_int", {63'd0, tim_int}, 64'd0);
    check("masked_int_st", {63'd0, int_st}, 64'd1);
    cnt_en = 1; tick(); cnt_en = 0;
    int_clr = 1; tick(); int_clr = 0;
    check("clr_masked", {63'd0, int_st}, 64'd0);

    // All-ones wrap to 0 with compare at 0
    int_en = 1;
    wr_cmp(1, 1, 32'd0);
    wr_cnt(1, 1, 32'hFFFF_FFFF);
    check("all_ones_cnt", cnt_val, {64{1'b1}});
    cnt_en = 1; tick(); cnt_en = 0;
    check("wrap_cnt", cnt_val, 64'd0);
    check("wrap_int_before", {63'd0, int_st}, 64'd0);
    tick();
    check("wrap_int_after", {63'd0, int_st}, 64'd1);
    wr_cmp(1, 0, 32'd1000);
    int_clr = 1; tick(); int_clr = 0;

    // Write beats a simultaneous tick
    wr_cnt(1, 1, 32'd0);
    wr_cnt(1, 0, 32'd3);
    cnt_lo_wr = 1; wdata = 32'd7; cnt_en = 1; tick(); clr_strobes();
    check("wr_beats_inc", cnt_val, 64'd7);

    // Disable clears, ticks while disabled are dropped
    wr_cnt(1, 0, 32'd20);
    check("pre_dis_cnt", cnt_val, 64'd20);
    timer_en = 0; tick();
    check("dis_clear", cnt_val, 64'd0);
    for (int i = 0; i < 3; i++) begin
      cnt_en = 1; tick(); cnt_en = 0; tick();
    end
    check("dis_ticks_dropped", cnt_val, 64'd0);
    timer_en = 1; tick();

    // Debug halt
    wr_cnt(1, 0, 32'd9);
    dbg_mode = 1; halt_req = 1; tick();
    check("halt_ack_rise", {63'd0, halt_ack}, 64'd1);
    check("halt_cnt", cnt_val, 64'd9);
    cnt_en = 1;
    repeat (3) tick();
    check("halt_hold", cnt_val, 64'd9);
    halt_req = 0; tick();
    check("halt_ack_fall", {63'd0, halt_ack}, 64'd0);
    check("halt_fall_cnt", cnt_val, 64'd9);
    tick();
    check("resume_cnt", cnt_val, 64'd10);
    halt_req = 1; tick(); cnt_en = 0;
    check("rehalt_ack", {63'd0, halt_ack}, 64'd1);

    // Asynchronous reset mid-halt
    sys_rst = 1;
    #1;
    check("arst_cnt", cnt_val, 64'd0);
    check("arst_cmp", cmp_val, {64{1'b1}});
    check("arst_int_st", {63'd0, int_st}, 64'd0);
    check("arst_tim_int", {63'd0, tim_int}, 64'd0);
    check("arst_halt_ack", {63'd0, halt_ack}, 64'd0);
    dbg_mode = 0; halt_req = 0;
    tick();
    sys_rst = 0;
    tick();
    check("post_rst_idle", cnt_val, 64'd0);
    cnt_en = 1; tick(); cnt_en = 0;
    check("post_rst_inc", cnt_val, 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
